bus_master_port: RTL and testbench

Serial bus initiator that drives one slave memory port of the ADS bus. It accepts a parallel read or write request from the local user side and serializes address and write data onto the 1-bit bus lines. For reads, it deserializes the slave's 1-bit read response back into a parallel word. It sits between a master-side controller and the slave memory block; later, the arbiter instantiates one per master.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_shreg.sv | 31 +++
 rtl/bus_master_port.sv | 220 ++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared ADS bus definitions: transaction FSM states and default widths.
// Reused by the master port, slave memory and arbiter.
package bus_pkg;

    localparam int unsigned BUS_N   = 8;
    localparam int unsigned BUS_ADN = 12;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        RWAIT,
        RDATA,
        DONE
    } busState_t;

endpackage

// File: rtl/bus_shreg.sv
// Shift register with parallel load, MSB-first serial out and LSB-side serial in.
// Load takes priority over shift.
module bus_shreg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [Width-1:0] loadData,
    input  logic             shift,
    input  logic             serialIn,
    output logic             serialOut,
    output logic [Width-1:0] parallelOut
);

    logic [Width-1:0] dataQ;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dataQ <= '0;
        end else if (load) begin
            dataQ <= loadData;
        end else if (shift) begin
            dataQ <= Width'({dataQ, serialIn});
        end
    end

    assign serialOut   = dataQ[Width-1];
    assign parallelOut = dataQ;

endmodule

// File: rtl/bus_master_port.sv
// ADS bus initiator: serializes a parallel read/write request onto the 1-bit bus
// and deserializes the slave's serial read response.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int unsigned N       = BUS_N,
    parameter int unsigned ADN     = BUS_ADN,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req,
    input  logic           req_wren,
    input  logic [ADN-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           req_ready,
    output logic           done,
    output logic [N-1:0]   rsp_rdata,
    output logic           rsp_err,
    output logic           valid,
    output logic           wren,
    output logic           addr_bit,
    output logic           wdata_bit,
    input  logic           slave_ready,
    input  logic           rd_valid,
    input  logic           rd_data
);

    localparam int unsigned CW = $clog2(ADN) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] WSTART   = CW'(ADN - N);
    localparam logic [CW-1:0] LASTADDR = CW'(ADN - 1);
    localparam logic [CW-1:0] LASTBIT  = CW'(N - 1);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);

    busState_t      stateQ, stateD;
    logic [CW-1:0]  cntQ, cntD, cntInc;
    logic [TW-1:0]  tcntQ, tcntD;
    logic           validQ, validD;
    logic           wrenQ, wrenD;
    logic           addrBitQ, addrBitD;
    logic           wdataBitQ, wdataBitD;
    logic           doneQ, doneD;
    logic           errQ, errD;
    logic [N-1:0]   rdataQ, rdataD;

    logic           accept;
    logic           addrShift, wdataShift, rdShift;
    logic           addrSer, wdataSer;
    logic [N-1:0]   rdWord;

    assign req_ready = (stateQ == IDLE) && slave_ready;
    assign accept    = req_ready && req;
    assign cntInc    = cntQ + CW'(1);

    bus_shreg #(.Width(ADN)) uAddrShreg (
        .clk         (clk),
        .rstn        (rstn),
        .load        (accept),
        .loadData    (req_addr),
        .shift       (addrShift),
        .serialIn    (1'b0),
        .serialOut   (addrSer),
        .parallelOut ()
    );

    bus_shreg #(.Width(N)) uWdataShreg (
        .clk         (clk),
        .rstn        (rstn),
        .load        (accept),
        .loadData    (req_wdata),
        .shift       (wdataShift),
        .serialIn    (1'b0),
        .serialOut   (wdataSer),
        .parallelOut ()
    );

    bus_shreg #(.Width(N)) uRdataShreg (
        .clk         (clk),
        .rstn        (rstn),
        .load        (accept),
        .loadData    ('0),
        .shift       (rdShift),
        .serialIn    (rd_data),
        .serialOut   (),
        .parallelOut (rdWord)
    );

    // Next-state logic also computes the value every bus line takes in the next cycle,
    // so all outputs come straight from flops.
    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        tcntD      = tcntQ;
        validD     = 1'b0;
        wrenD      = wrenQ;
        addrBitD   = 1'b0;
        wdataBitD  = 1'b0;
        doneD      = 1'b0;
        errD       = 1'b0;
        rdataD     = rdataQ;
        addrShift  = 1'b0;
        wdataShift = 1'b0;
        rdShift    = 1'b0;

        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateD = REQ;
                    validD = 1'b1;
                    wrenD  = req_wren;
                    cntD   = '0;
                    tcntD  = '0;
                end
            end
            REQ: begin
                stateD    = ADDR;
                validD    = 1'b1;
                cntD      = '0;
                addrBitD  = addrSer;
                addrShift = 1'b1;
                if (WSTART == '0) begin
                    wdataBitD  = wdataSer;
                    wdataShift = 1'b1;
                end
            end
            ADDR: begin
                if (cntQ == LASTADDR) begin
                    if (wrenQ) begin
                        stateD = DONE;
                        doneD  = 1'b1;
                        wrenD  = 1'b0;
                    end else begin
                        stateD = RWAIT;
                        tcntD  = '0;
                    end
                end else begin
                    cntD      = cntInc;
                    validD    = 1'b1;
                    addrBitD  = addrSer;
                    addrShift = 1'b1;
                    // Write data is right-aligned to the end of the address phase.
                    if (cntInc >= WSTART) begin
                        wdataBitD  = wdataSer;
                        wdataShift = 1'b1;
                    end
                end
            end
            RWAIT: begin
                if (rd_valid) begin
                    stateD = RDATA;
                    cntD   = '0;
                end else if (tcntQ == TLAST) begin
                    stateD = DONE;
                    doneD  = 1'b1;
                    errD   = 1'b1;
                    rdataD = '0;
                    wrenD  = 1'b0;
                end else begin
                    tcntD = tcntQ + TW'(1);
                end
            end
            RDATA: begin
                rdShift = 1'b1;
                if (cntQ == LASTBIT) begin
                    stateD = DONE;
                    doneD  = 1'b1;
                    wrenD  = 1'b0;
                    rdataD = N'({rdWord, rd_data});
                end else begin
                    cntD = cntInc;
                end
            end
            DONE: begin
                stateD = IDLE;
                wrenD  = 1'b0;
            end
            default: begin
                stateD = IDLE;
                wrenD  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            tcntQ     <= '0;
            validQ    <= 1'b0;
            wrenQ     <= 1'b0;
            addrBitQ  <= 1'b0;
            wdataBitQ <= 1'b0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
            rdataQ    <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            tcntQ     <= tcntD;
            validQ    <= validD;
            wrenQ     <= wrenD;
            addrBitQ  <= addrBitD;
            wdataBitQ <= wdataBitD;
            doneQ     <= doneD;
            errQ      <= errD;
            rdataQ    <= rdataD;
        end
    end

    assign valid     = validQ;
    assign wren      = wrenQ;
    assign addr_bit  = addrBitQ;
    assign wdata_bit = wdataBitQ;
    assign done      = doneQ;
    assign rsp_err   = errQ;
    assign rsp_rdata = rdataQ;

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port with a behavioural serial slave memory.
module tb_bus_master_port;
    import bus_pkg::*;

    localparam int unsigned N       = BUS_N;
    localparam int unsigned ADN     = BUS_ADN;
    localparam int unsigned TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rstn;
    logic           req;
    logic           req_wren;
    logic [ADN-1:0] req_addr;
    logic [N-1:0]   req_wdata;
    logic           req_ready;
    logic           done;
    logic [N-1:0]   rsp_rdata;
    logic           rsp_err;
    logic           valid;
    logic           wren;
    logic           addr_bit;
    logic           wdata_bit;
    logic           slave_ready;
    logic           rd_valid;
    logic           rd_data;

    bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .req_wren    (req_wren),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .valid       (valid),
        .wren        (wren),
        .addr_bit    (addr_bit),
        .wdata_bit   (wdata_bit),
        .slave_ready (slave_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] rdata;
        logic         err;
        logic         chkData;
        int           doneCyc;
    } rspExp_t;

    typedef struct {
        logic           wren;
        logic [ADN-1:0] addr;
        logic [ADN-1:0] wbits;
    } busExp_t;

    rspExp_t rspQ[$];
    busExp_t busQ[$];

    int   nCompared = 0;
    int   nMismatch = 0;
    logic respEn    = 1'b1;
    logic [N-1:0] mem [0:(1<<ADN)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input logic w, input logic [ADN-1:0] a, input logic [N-1:0] d,
                           input logic [N-1:0] expR, input logic expErr, input int t);
        busExp_t b;
        rspExp_t r;
        b.wren    = w;
        b.addr    = a;
        b.wbits   = ADN'(d);
        r.rdata   = expR;
        r.err     = expErr;
        r.chkData = !w;
        r.doneCyc = w ? t + ADN + 1 : (expErr ? t + ADN + 1 + TIMEOUT : t + ADN + N + 3);
        busQ.push_back(b);
        rspQ.push_back(r);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic w, input logic [ADN-1:0] a, input logic [N-1:0] d,
                         input logic [N-1:0] expR, input logic expErr, input logic track,
                         output int acc);
        bit got = 0;
        acc       = -1;
        req       = 1'b1;
        req_wren  = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check("accept timeout", 32'(req_ready), 32'd1);
        end else begin
            acc = cyc + 1;
            if (track) pushExp(w, a, d, expR, expErr, acc);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic drain();
        bit empty = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rspQ.size() == 0 && busQ.size() == 0) begin
                empty = 1;
                break;
            end
        end
        if (!empty) check("drain timeout", 32'(rspQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor
    initial begin
        rspExp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (rspQ.size() == 0) begin
                    check("done without request", 32'(done), 32'd0);
                end else begin
                    e = rspQ.pop_front();
                    check("done cycle", 32'(cyc), 32'(e.doneCyc));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.chkData) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    // Slave model: captures the serial request, checks it, stores writes, answers reads.
    initial begin
        logic           w, a0, d0, aborted, validAfter;
        logic [ADN-1:0] capA, capD;
        logic [N-1:0]   word;
        busExp_t        e;
        rd_valid = 1'b0;
        rd_data  = 1'b0;
        capA     = '0;
        capD     = '0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && rstn === 1'b1) begin
                w       = wren;
                a0      = addr_bit;
                d0      = wdata_bit;
                aborted = 1'b0;
                for (int k = 0; k < ADN; k++) begin
                    @(negedge clk);
                    if (valid !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    capA = {capA[ADN-2:0], addr_bit};
                    capD = {capD[ADN-2:0], wdata_bit};
                end
                if (!aborted) begin
                    @(negedge clk);
                    validAfter = valid;
                    if (busQ.size() == 0) begin
                        check("bus txn without request", 32'(busQ.size()), 32'd1);
                    end else begin
                        e = busQ.pop_front();
                        check("REQ-cycle data lines", {30'd0, a0, d0}, 32'd0);
                        check("wren", 32'(w), 32'(e.wren));
                        check("addr serial", 32'(capA), 32'(e.addr));
                        check("wdata serial", 32'(capD), 32'(e.wbits));
                        check("valid after addr phase", 32'(validAfter), 32'd0);
                    end
                    if (w) begin
                        mem[capA] = capD[N-1:0];
                    end else if (respEn) begin
                        word = mem[capA];
                        @(posedge clk);
                        #1 rd_valid = 1'b1;
                        @(posedge clk);
                        #1 rd_valid = 1'b0;
                        for (int i = N - 1; i >= 0; i--) begin
                            rd_data = word[i];
                            @(posedge clk);
                            #1;
                        end
                        rd_data = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3;
        for (int i = 0; i < (1 << ADN); i++) mem[i] = '0;
        mem[12'h001] = 8'hC3;

        rstn        = 1'b0;
        req         = 1'b0;
        req_wren    = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        slave_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset valid", 32'(valid), 32'd0);
        check("reset wren", 32'(wren), 32'd0);
        check("reset addr_bit", 32'(addr_bit), 32'd0);
        check("reset wdata_bit", 32'(wdata_bit), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Write 0x3E to 0xA5C
        issue(1'b1, 12'hA5C, 8'h3E, 8'h00, 1'b0, 1'b1, t1);
        drain();

        // Read 0x001, responder returns 0xC3
        issue(1'b0, 12'h001, 8'h00, 8'hC3, 1'b0, 1'b1, t1);
        drain();

        // Read with no response: timeout
        respEn = 1'b0;
        issue(1'b0, 12'h123, 8'h00, 8'h00, 1'b1, 1'b1, t1);
        drain();
        respEn = 1'b1;

        // req held while slave not ready: no bus activity
        slave_ready = 1'b0;
        req         = 1'b1;
        req_wren    = 1'b1;
        req_addr    = 12'h0F0;
        req_wdata   = 8'h81;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("not-ready valid", 32'(valid), 32'd0);
            check("not-ready req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 slave_ready = 1'b1;
        pushExp(1'b1, 12'h0F0, 8'h81, 8'h00, 1'b0, cyc + 1);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("REQ cycle after ready", 32'(valid), 32'd1);
        drain();

        // Back-to-back write then read of the same location
        mem[12'hA5C] = 8'h00;
        issue(1'b1, 12'hA5C, 8'h3E, 8'h00, 1'b0, 1'b1, t1);
        issue(1'b0, 12'hA5C, 8'h00, 8'h3E, 1'b0, 1'b1, t2);
        check("re-accept spacing", 32'(t2 - t1), 32'(ADN + 3));
        drain();

        // Read back the write issued under slave_ready gating
        issue(1'b0, 12'h0F0, 8'h00, 8'h81, 1'b0, 1'b1, t1);
        drain();

        // Reset during ADDR cycle 5 of a write
        issue(1'b1, 12'h555, 8'hAA, 8'h00, 1'b0, 1'b0, t3);
        repeat (7) @(negedge clk);
        check("valid before reset", 32'(valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("valid in reset", 32'(valid), 32'd0);
        check("wren in reset", 32'(wren), 32'd0);
        check("done in reset", 32'(done), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("req_ready after reset", 32'(req_ready), 32'd1);
        check("valid after reset", 32'(valid), 32'd0);
        slave_ready = 1'b0;
        #1;
        check("req_ready follows slave_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 slave_ready = 1'b1;

        // Normal operation resumes after reset
        issue(1'b0, 12'h001, 8'h00, 8'hC3, 1'b0, 1'b1, t1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
